piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/serial_pkg.sv | 12 +
 rtl/piso_serializer_if.sv | 37 +++
 rtl/serial_hold_reg.sv | 46 ++++
 rtl/piso_serializer.sv | 123 ++++++++++++
 tb/tb_piso_serializer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: serializer state encoding and default word width.
// The downstream sequence detector imports this package as well.
package serial_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } serial_state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-in / serial-out link bundle. master = upstream word source and serial sink,
// slave = the serializer itself.
interface piso_serializer_if
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  sout,
    input  sout_valid,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output sout,
    output sout_valid,
    output frame_start,
    output busy
  );

endinterface

// File: rtl/serial_hold_reg.sv
// One-word holding register with a full flag; the second storage slot behind the shifter.
module serial_hold_reg
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             take_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  // Next state: a take empties the slot, a load fills it (a load wins if both occur).
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (take_i) begin
      full_d = 1'b0;
    end
    if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-to-serial converter with a shifter plus one holding word (2-word capacity).
// Words stream back to back with no idle cycle; sout/sout_valid/frame_start are registered.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst,
  piso_serializer_if.slave bus
);

  localparam int unsigned      CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);

  serial_state_e    state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_start_q, frame_start_d;

  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             din_ready;
  logic             accept;
  logic             last_bit;
  logic             shifter_free;
  logic             hold_take;
  logic             hold_load;
  logic             load_sh;
  logic [WIDTH-1:0] load_word;

  // Transfer control. cnt_q is the index of the bit currently on sout, so the shifter
  // frees up during the cycle that presents bit WIDTH-1.
  always_comb begin
    din_ready    = ~hold_full & ~rst;
    accept       = bus.din_valid & din_ready;
    last_bit     = (state_q == StShift) && (cnt_q == LastCnt);
    shifter_free = (state_q == StIdle) || last_bit;
    hold_take    = shifter_free & hold_full;
    load_sh      = shifter_free & (hold_full | accept);
    // Only bypass the holding register when it is empty and the shifter can take the word.
    hold_load    = accept & ~(shifter_free & ~hold_full);
    load_word    = hold_full ? hold_data : bus.din;
  end

  serial_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load_i (hold_load),
    .data_i (bus.din),
    .take_i (hold_take),
    .data_o (hold_data),
    .full_o (hold_full)
  );

  // FSM next state and registered serial outputs; the first bit leaves at load time.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    sout_d        = 1'b0;
    sout_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    if (load_sh) begin
      state_d       = StShift;
      cnt_d         = '0;
      sout_valid_d  = 1'b1;
      frame_start_d = 1'b1;
      if (MSB_FIRST) begin
        sout_d  = load_word[WIDTH-1];
        shreg_d = load_word << 1;
      end else begin
        sout_d  = load_word[0];
        shreg_d = load_word >> 1;
      end
    end else if (last_bit) begin
      state_d = StIdle;
      shreg_d = '0;
      cnt_d   = '0;
    end else if (state_q == StShift) begin
      cnt_d        = cnt_q + CntW'(1);
      sout_valid_d = 1'b1;
      if (MSB_FIRST) begin
        sout_d  = shreg_q[WIDTH-1];
        shreg_d = shreg_q << 1;
      end else begin
        sout_d  = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      cnt_q         <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.din_ready   = din_ready;
  assign bus.sout        = sout_q;
  assign bus.sout_valid  = sout_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = (state_q == StShift) | hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: accepted words push their expected bit stream into a queue, and a
// negedge monitor pops and compares whenever sout_valid is high.
module tb_piso_serializer;
  import serial_pkg::*;

  typedef struct packed {
    logic b;
    logic fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) bus_m ();
  piso_serializer_if #(.WIDTH(8)) bus_l ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  exp_t     q_m[$];
  exp_t     q_l[$];
  int       errors = 0;
  int       checks = 0;
  bit       mon_en = 1'b0;
  bit [1:0] burst  = 2'b00;
  logic [3:0] hist_m = 4'b0000;
  int       det_cnt = 0;

  function automatic void check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endfunction

  function automatic void checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void push_word(input bit lsb, input logic [7:0] w);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.b  = lsb ? w[i] : w[7-i];
      e.fs = (i == 0);
      if (lsb) q_l.push_back(e);
      else     q_m.push_back(e);
    end
  endfunction

  function automatic void mon_one(input bit lsb);
    logic  v, s, f;
    int    n;
    exp_t  e;
    string tag;
    tag = lsb ? "lsb" : "msb";
    v = lsb ? bus_l.sout_valid  : bus_m.sout_valid;
    s = lsb ? bus_l.sout        : bus_m.sout;
    f = lsb ? bus_l.frame_start : bus_m.frame_start;
    n = lsb ? q_l.size() : q_m.size();
    if (v) begin
      if (!lsb) begin
        hist_m = {hist_m[2:0], s};
        if (hist_m == 4'b1101) det_cnt++;
      end
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_bit: got sout=%0b expected no valid bit", tag, s);
      end else begin
        if (lsb) e = q_l.pop_front();
        else     e = q_m.pop_front();
        check1({tag, "_bit"}, s, e.b);
        check1({tag, "_frame_start"}, f, e.fs);
        burst[lsb] = 1'b1;
      end
    end else begin
      check1({tag, "_idle_sout"}, s, 1'b0);
      check1({tag, "_idle_frame_start"}, f, 1'b0);
      if (burst[lsb] && n != 0) begin
        checks++;
        errors++;
        $display("FAIL %s_gap: got sout_valid=0 expected 1 (%0d bits pending)", tag, n);
      end
      burst[lsb] = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      mon_one(1'b0);
      mon_one(1'b1);
    end
  end

  // Offer a word until accepted; returns having left din_valid high, at posedge+1.
  task automatic offer(input bit lsb, input logic [7:0] w, output int waited);
    logic rdy;
    bit   acc;
    acc    = 1'b0;
    waited = 0;
    if (lsb) begin bus_l.din = w; bus_l.din_valid = 1'b1; end
    else     begin bus_m.din = w; bus_m.din_valid = 1'b1; end
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      rdy = lsb ? bus_l.din_ready : bus_m.din_ready;
      @(posedge clk);
      if (rdy) begin
        push_word(lsb, w);
        acc = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no transfer of %0h expected one within 40 cycles", w);
    end
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      if (q_m.size() == 0 && q_l.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d bits pending expected 0", q_m.size(), q_l.size());
    end
    #1;
  endtask

  initial begin
    int w;
    rst             = 1'b1;
    bus_m.din       = '0;
    bus_m.din_valid = 1'b0;
    bus_l.din       = '0;
    bus_l.din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_sout_valid", bus_m.sout_valid, 1'b0);
    check1("rst_sout", bus_m.sout, 1'b0);
    check1("rst_frame_start", bus_m.frame_start, 1'b0);
    check1("rst_busy", bus_m.busy, 1'b0);
    check1("rst_din_ready", bus_m.din_ready, 1'b0);
    check1("rst_lsb_busy", bus_l.busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check1("post_rst_din_ready", bus_m.din_ready, 1'b1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // D0 MSB-first: 11010000, first bit right after the accepting edge.
    hist_m  = 4'b0000;
    det_cnt = 0;
    offer(1'b0, 8'hD0, w);
    bus_m.din_valid = 1'b0;
    check1("d0_latency_valid", bus_m.sout_valid, 1'b1);
    check1("d0_latency_frame_start", bus_m.frame_start, 1'b1);
    check1("d0_busy", bus_m.busy, 1'b1);
    drain();
    checki("d0_1101_detect_count", det_cnt, 1);

    // 0B LSB-first: 11010000.
    offer(1'b1, 8'h0B, w);
    bus_l.din_valid = 1'b0;
    check1("0b_latency_valid", bus_l.sout_valid, 1'b1);
    drain();

    // A5 then 3C on consecutive cycles: 16 contiguous bits.
    offer(1'b0, 8'hA5, w);
    offer(1'b0, 8'h3C, w);
    checki("a5_3c_second_wait", w, 0);
    bus_m.din_valid = 1'b0;
    drain();

    // Three words with din_valid held: third stalls until the holding slot drains.
    offer(1'b0, 8'hC3, w);
    offer(1'b0, 8'h5A, w);
    checki("three_second_wait", w, 0);
    check1("three_ready_low", bus_m.din_ready, 1'b0);
    check1("three_busy", bus_m.busy, 1'b1);
    offer(1'b0, 8'h96, w);
    check1("three_third_stalled", (w > 0), 1'b1);
    bus_m.din_valid = 1'b0;
    drain();

    // Reset mid-word with a word held, then a clean word.
    offer(1'b0, 8'hFF, w);
    offer(1'b0, 8'h0F, w);
    bus_m.din_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst             = 1'b1;
    bus_m.din       = 8'h55;
    bus_m.din_valid = 1'b1;
    #1;
    check1("rst_forces_ready_low", bus_m.din_ready, 1'b0);
    @(posedge clk);
    q_m.delete();
    q_l.delete();
    burst = 2'b00;
    #1;
    check1("midrst_sout_valid", bus_m.sout_valid, 1'b0);
    check1("midrst_sout", bus_m.sout, 1'b0);
    check1("midrst_frame_start", bus_m.frame_start, 1'b0);
    check1("midrst_busy", bus_m.busy, 1'b0);
    rst             = 1'b0;
    bus_m.din_valid = 1'b0;
    @(posedge clk);
    #1;
    check1("midrst_no_transfer_busy", bus_m.busy, 1'b0);
    check1("midrst_no_transfer_valid", bus_m.sout_valid, 1'b0);
    offer(1'b0, 8'h81, w);
    bus_m.din_valid = 1'b0;
    drain();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
